tdm_demux: RTL
==============

# tdm_demux

Time-division demultiplexer: the receive end of a serial time-division link driven by a select-counter mux. It accepts one bit per valid cycle, tracks the current slot with a mod-2^n counter aligned by a frame-sync marker, and steers each bit into the matching position of a shadow register. When the last slot lands, it publishes the full parallel word with a one-cycle valid pulse. It sits in the select-circuits library beside the combinational mux and recovers the mux's parallel input from its time-sliced output.

## Interface
- `n`, 2, select width; the frame has N = 2^n slots.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `in_bit` input 1: serial data bit for the current slot.
- `in_valid` input 1: `in_bit` is sampled only on edges where this is 1.
- `frame_sync` input 1: qualified by `in_valid`; marks the current bit as slot 0.
- `out` output N: last complete frame; bit i = slot i.
- `out_valid` output 1: one-cycle pulse when `out` updates.
- `slot` output n: slot index the next accepted bit will occupy.
- `locked` output 1: 1 while in RUN.
- `sync_err` output 1: present only with `TDM_DEMUX_SYNC_ERR_EN`; one-cycle pulse.

## Operation
- States: HUNT, RUN. Reset state is HUNT.
- Reset values: `out`=0, `out_valid`=0, `slot`=0, `locked`=0, `sync_err`=0, shadow=0.
- HUNT, accepted bit with `frame_sync`=0: discarded; `slot` stays 0.
- HUNT, accepted bit with `frame_sync`=1: stored as shadow[0]; `slot` becomes 1; go to RUN.
- RUN, accepted bit: stored as shadow[`slot`]; `slot` increments modulo N.
- RUN, accepted bit at `slot`=N-1: `out` is loaded with the shadow word, with bit N-1 taken from `in_bit` in the same edge; `out_valid` pulses; `slot` wraps to 0; state stays RUN.
- RUN, accepted bit at `slot`=0 with `frame_sync`=0: accepted normally. The link is allowed to freewheel.
- Cycles with `in_valid`=0: no state change. Gaps between slots are allowed and have no limit.
- `out` holds its value between frames. Shadow bits are not cleared between frames; every slot is overwritten each frame.
- A partial frame is never published.
- N=2 (n=1) is legal. n=0 is unsupported.

## Timing
- Accept edge: a rising edge with `in_valid`=1.
- `out` and `out_valid` are registered. They update on the accept edge of slot N-1 and are visible in the following cycle.
- Latency from last-slot bit to `out_valid` is 1 cycle. `out_valid` is never high two cycles in a row unless two frames complete on consecutive edges (only possible when N=1, so never in practice).
- `slot` and `locked` update on the accept edge.
- Asserting `rst` at any time forces all outputs to their reset values immediately. Any partial frame is lost. After release, the block is back in HUNT.

## Configuration
- Macro: `TDM_DEMUX_SYNC_ERR_EN`.
- Defined:
  - The `sync_err` port exists.
  - In RUN, an accepted bit with `frame_sync`=1 at `slot`≠0 pulses `sync_err` for one cycle after the edge.
  - The partial frame is discarded and the bit is stored as shadow[0]; `slot` becomes 1.
  - `out` and `out_valid` are unaffected by the resync.
- Undefined:
  - No `sync_err` port.
  - `frame_sync` is ignored in RUN.
  - Misaligned sync is treated as an ordinary data bit.

## Structure
- Shared header/package `tdm_defs`: state encodings (`HUNT`, `RUN`) and the slot-count helper N = 1<<n.
- One natural sub-module, `mod_counter`: a parameterised n-bit wrapping counter with `clk`, `rst`, `en`, `load0`, `load1` and a `wrap` flag. The top level holds the FSM, the shadow register and the output register.

## Test plan
- n=2, reset, then frame_sync+bits 0,1,0,1 on four consecutive cycles -> `out`=4'b1010, `out_valid` pulses once in cycle 5, `locked`=1.
- Three bits without frame_sync, then a valid frame 1,1,0,0 -> first three bits ignored; `out`=4'b0011.
- Back-to-back frames 1010, then 1111 (no sync on the second) with `in_valid` gaps of 0–3 cycles -> `out` goes 4'b0101 then 4'b1111; exactly two `out_valid` pulses.
- With the macro defined: sync, bits 1,1, then frame_sync at slot 2 followed by 0,0,1,1 -> `sync_err` pulses once; `out`=4'b1100; no publish of the partial frame.
- Assert `rst` after slot 1 of a frame, release, then send a full frame 0110 -> immediate zeroed outputs and HUNT; `out`=4'b0110 afterwards.
- Hold `in_valid`=0 for 20 cycles mid-frame -> `slot`, `out` and `locked` unchanged; the frame completes correctly when bits resume.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// ----------------------------------------------------------------------------
// tdm_demux_pkg: shared definitions for the TDM demultiplexer slice.
//   state_e    : receiver FSM encodings (HUNT, RUN)
//   slot_count : number of frame slots for a given select width (N = 1 << n)
// ----------------------------------------------------------------------------
package tdm_demux_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Frame length for select width n.
  function automatic int unsigned slot_count(input int unsigned n);
    return 32'(1) << n;
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// ----------------------------------------------------------------------------
// tdm_demux_if: serial link input and parallel frame output of tdm_demux.
//   Parameter n : select width, frame has 1 << n slots.
//   in_bit, in_valid, frame_sync : serial side, driven by the master.
//   out, out_valid, slot, locked : parallel side, driven by the slave (DUT).
//   sync_err : only when TDM_DEMUX_SYNC_ERR_EN is defined.
// ----------------------------------------------------------------------------
interface tdm_demux_if #(
  parameter int unsigned n = 2
);
  import tdm_demux_pkg::*;

  localparam int unsigned N = slot_count(n);

  logic         in_bit;
  logic         in_valid;
  logic         frame_sync;
  logic [N-1:0] out;
  logic         out_valid;
  logic [n-1:0] slot;
  logic         locked;
`ifdef TDM_DEMUX_SYNC_ERR_EN
  logic         sync_err;

  modport master (
    output in_bit, in_valid, frame_sync,
    input  out, out_valid, slot, locked, sync_err
  );

  modport slave (
    input  in_bit, in_valid, frame_sync,
    output out, out_valid, slot, locked, sync_err
  );
`else
  modport master (
    output in_bit, in_valid, frame_sync,
    input  out, out_valid, slot, locked
  );

  modport slave (
    input  in_bit, in_valid, frame_sync,
    output out, out_valid, slot, locked
  );
`endif

endinterface

// File: rtl/tdm_demux_mod_counter.sv
// ----------------------------------------------------------------------------
// tdm_demux_mod_counter: W-bit wrapping slot counter.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance by one (mod 2^W)
//   load0    : force count to 0 (highest priority)
//   load1    : force count to 1 (frame start: slot 0 consumed this edge)
//   cnt_o    : current count (registered)
//   wrap_c   : combinational, high when this edge advances from 2^W-1 to 0
// ----------------------------------------------------------------------------
module tdm_demux_mod_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load0,
  input  logic         load1,
  output logic [W-1:0] cnt_o,
  output logic         wrap_c
);

  logic [W-1:0] cnt_q;

  // Count register; loads take priority over the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load0) begin
      cnt_q <= '0;
    end else if (load1) begin
      cnt_q <= W'(1);
    end else if (en) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_c = en & ~load0 & ~load1 & (cnt_q == {W{1'b1}});

endmodule

// File: rtl/tdm_demux.sv
// ----------------------------------------------------------------------------
// tdm_demux: receive end of a serial time-division link.
//   Collects one bit per in_valid cycle into a shadow register at the slot
//   given by a frame_sync-aligned counter and publishes the whole word on
//   out with a one-cycle out_valid pulse when slot N-1 is accepted.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : tdm_demux_if slave modport (serial in, parallel out)
//   Optional: define TDM_DEMUX_SYNC_ERR_EN to resynchronise on a misaligned
//   frame_sync in RUN and flag it on bus.sync_err.
// ----------------------------------------------------------------------------
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int unsigned n = 2
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux_if.slave   bus
);

  localparam int unsigned N = slot_count(n);

  state_e       state_q, state_d;
  logic [N-1:0] shadow_q, shadow_d;
  logic [N-1:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic         cnt_en, cnt_load1;
  logic         wrap_c;
  logic [n-1:0] slot;
`ifdef TDM_DEMUX_SYNC_ERR_EN
  logic         sync_err_q, sync_err_d;
`endif

  tdm_demux_mod_counter #(.W(n)) u_slot_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (cnt_en),
    .load0  (1'b0),
    .load1  (cnt_load1),
    .cnt_o  (slot),
    .wrap_c (wrap_c)
  );

  // State, shadow and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      shadow_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef TDM_DEMUX_SYNC_ERR_EN
      sync_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef TDM_DEMUX_SYNC_ERR_EN
      sync_err_q  <= sync_err_d;
`endif
    end
  end

  // Next-state, slot steering and frame publish.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    cnt_en      = 1'b0;
    cnt_load1   = 1'b0;
`ifdef TDM_DEMUX_SYNC_ERR_EN
    sync_err_d  = 1'b0;
`endif

    unique case (state_q)
      HUNT: begin
        if (bus.in_valid && bus.frame_sync) begin
          shadow_d[0] = bus.in_bit;
          cnt_load1   = 1'b1;
          state_d     = RUN;
        end
      end

      RUN: begin
        if (bus.in_valid) begin
`ifdef TDM_DEMUX_SYNC_ERR_EN
          if (bus.frame_sync && (slot != '0)) begin
            // Misaligned marker: drop the partial frame and restart at slot 0.
            shadow_d[0] = bus.in_bit;
            cnt_load1   = 1'b1;
            sync_err_d  = 1'b1;
          end else begin
`endif
            shadow_d[slot] = bus.in_bit;
            cnt_en         = 1'b1;
            if (wrap_c) begin
              // Last slot bypasses the shadow so the word publishes this edge.
              out_d        = shadow_q;
              out_d[N-1]   = bus.in_bit;
              out_valid_d  = 1'b1;
            end
`ifdef TDM_DEMUX_SYNC_ERR_EN
          end
`endif
        end
      end

      default: state_d = HUNT;
    endcase
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.slot      = slot;
  assign bus.locked    = (state_q == RUN);
`ifdef TDM_DEMUX_SYNC_ERR_EN
  assign bus.sync_err  = sync_err_q;
`endif

endmodule
